// File: rtl/regfile_mp.sv
// Multi-read-port GPR file with a HI/LO register pair; GPR 0 reads as zero.
// Optional same-cycle write-to-read forwarding is built when REGFILE_BYPASS_EN is defined.
module regfile_mp #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     we,
   input  logic [ADDR_W-1:0]        waddr,
   input  logic [DATA_W-1:0]        wdata,
   input  logic [NUM_RD-1:0]        re,
   input  logic [NUM_RD*ADDR_W-1:0] raddr,
   output logic [NUM_RD*DATA_W-1:0] rdata,
   input  logic                     hilo_we,
   input  logic [DATA_W-1:0]        hi_wdata,
   input  logic [DATA_W-1:0]        lo_wdata,
   output logic [DATA_W-1:0]        hi_rdata,
   output logic [DATA_W-1:0]        lo_rdata
);

   localparam int NUM_REGS = 2 ** ADDR_W;

   logic [DATA_W-1:0] regs [NUM_REGS];
   logic [DATA_W-1:0] hi;
   logic [DATA_W-1:0] lo;

   // Entry 0 is only ever cleared, so it stays zero; reads also mask it explicitly.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
         hi <= '0;
         lo <= '0;
      end else begin
         if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
         end
         if (hilo_we) begin
            hi <= hi_wdata;
            lo <= lo_wdata;
         end
      end
   end

   always_comb begin
      rdata = '0;
      for (int i = 0; i < NUM_RD; i++) begin
         if (!rst && re[i] && (raddr[i*ADDR_W +: ADDR_W] != '0)) begin
            rdata[i*DATA_W +: DATA_W] = regs[raddr[i*ADDR_W +: ADDR_W]];
`ifdef REGFILE_BYPASS_EN
            if (we && (waddr == raddr[i*ADDR_W +: ADDR_W])) begin
               rdata[i*DATA_W +: DATA_W] = wdata;
            end
`endif
         end
      end
   end

   always_comb begin
      hi_rdata = '0;
      lo_rdata = '0;
      if (!rst) begin
`ifdef REGFILE_BYPASS_EN
         if (hilo_we) begin
            hi_rdata = hi_wdata;
            lo_rdata = lo_wdata;
         end else begin
            hi_rdata = hi;
            lo_rdata = lo;
         end
`else
         hi_rdata = hi;
         lo_rdata = lo;
`endif
      end
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp (DATA_W=64, NUM_RD=4); expectations adapt to REGFILE_BYPASS_EN.
module tb_regfile_mp;

   localparam int DW = 64;
   localparam int AW = 5;
   localparam int NR = 4;
`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   // Output selectors: 0..3 read ports, 4 = HI, 5 = LO
   localparam int SEL_HI = 4;
   localparam int SEL_LO = 5;

   logic             clk = 1'b0;
   logic             rst;
   logic             we;
   logic [AW-1:0]    waddr;
   logic [DW-1:0]    wdata;
   logic [NR-1:0]    re;
   logic [NR*AW-1:0] raddr;
   logic [NR*DW-1:0] rdata;
   logic             hilo_we;
   logic [DW-1:0]    hi_wdata;
   logic [DW-1:0]    lo_wdata;
   logic [DW-1:0]    hi_rdata;
   logic [DW-1:0]    lo_rdata;

   regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
      .re(re), .raddr(raddr), .rdata(rdata),
      .hilo_we(hilo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata),
      .hi_rdata(hi_rdata), .lo_rdata(lo_rdata)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int            cyc;
      int            sel;
      logic [DW-1:0] val;
      string         name;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   checks = 0;
   int   errors = 0;
   bit   done   = 1'b0;
   logic [DW-1:0] act;

   function automatic logic [DW-1:0] actual(input int sel);
      if (sel == SEL_HI) return hi_rdata;
      if (sel == SEL_LO) return lo_rdata;
      return rdata[sel*DW +: DW];
   endfunction

   // Compare every expectation tagged with the current cycle; stale or leftover entries count as failures.
   always @(negedge clk) begin
      while (sb.size() > 0 && (done || sb[0].cyc <= cyc)) begin
         e = sb.pop_front();
         checks++;
         if (e.cyc != cyc) begin
            errors++;
            $display("[TB] FAIL %s: never sampled (queued cycle %0d, now %0d), required %h",
                     e.name, e.cyc, cyc, e.val);
         end else begin
            act = actual(e.sel);
            if (act !== e.val) begin
               errors++;
               $display("[TB] FAIL %s: got %h, required %h", e.name, act, e.val);
            end
         end
      end
   end

   task automatic applyStimulus(input logic r, input logic w, input logic [AW-1:0] wa,
                                input logic [DW-1:0] wd, input logic [NR-1:0] ren,
                                input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                input logic [AW-1:0] a2, input logic [AW-1:0] a3,
                                input logic hw, input logic [DW-1:0] hd, input logic [DW-1:0] ld);
      rst      = r;
      we       = w;
      waddr    = wa;
      wdata    = wd;
      re       = ren;
      raddr    = {a3, a2, a1, a0};
      hilo_we  = hw;
      hi_wdata = hd;
      lo_wdata = ld;
   endtask

   task automatic checkOutput(input int sel, input logic [DW-1:0] val, input string name);
      exp_t x;
      x.cyc  = cyc;
      x.sel  = sel;
      x.val  = val;
      x.name = name;
      sb.push_back(x);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step();

      // Reset held: outputs forced to zero even with reads enabled
      applyStimulus(1, 0, 0, 0, 4'hF, 5, 5, 5, 5, 1, 64'h9, 64'h9);
      checkOutput(0, 0, "rst_port0");
      checkOutput(3, 0, "rst_port3");
      checkOutput(SEL_HI, 0, "rst_hi");
      checkOutput(SEL_LO, 0, "rst_lo");
      step();

      // First cycle after release: write accepted, outputs from reset state
      applyStimulus(0, 1, 5, 64'hDEADBEEF, 4'h1, 5, 0, 0, 0, 0, 0, 0);
      checkOutput(0, BYP ? 64'hDEADBEEF : 64'h0, "release_write_r5");
      checkOutput(SEL_HI, 0, "release_hi");
      checkOutput(SEL_LO, 0, "release_lo");
      step();

      applyStimulus(0, 0, 0, 0, 4'h1, 5, 0, 0, 0, 0, 0, 0);
      checkOutput(0, 64'hDEADBEEF, "r5_after_write");
      step();

      // Reset wins over a simultaneous write
      applyStimulus(1, 1, 5, 64'h1, 4'h1, 5, 0, 0, 0, 0, 0, 0);
      checkOutput(0, 0, "rst_with_write_r5");
      step();

      applyStimulus(0, 0, 0, 0, 4'h1, 5, 0, 0, 0, 0, 0, 0);
      checkOutput(0, 0, "r5_cleared");
      step();

      applyStimulus(0, 1, 3, 64'h12345678, 4'h0, 3, 3, 0, 0, 0, 0, 0);
      checkOutput(0, 0, "re_off_port0");
      step();

      applyStimulus(0, 0, 0, 0, 4'h3, 3, 3, 0, 0, 0, 0, 0);
      checkOutput(0, 64'h12345678, "r3_port0");
      checkOutput(1, 64'h12345678, "r3_port1");
      step();

      applyStimulus(0, 0, 0, 0, 4'h1, 3, 3, 0, 0, 0, 0, 0);
      checkOutput(0, 64'h12345678, "r3_port0_only");
      checkOutput(1, 0, "port1_disabled");
      step();

      // Zero register ignores writes, also in the write cycle
      applyStimulus(0, 1, 0, 64'hFFFFFFFF_FFFFFFFF, 4'h1, 0, 0, 0, 0, 0, 0, 0);
      checkOutput(0, 0, "r0_write_cycle");
      step();

      applyStimulus(0, 0, 0, 0, 4'h1, 0, 0, 0, 0, 0, 0, 0);
      checkOutput(0, 0, "r0_after_write");
      step();

      applyStimulus(0, 1, 7, 64'hA, 4'h0, 0, 0, 0, 0, 0, 0, 0);
      step();

      applyStimulus(0, 1, 7, 64'hB, 4'h7, 7, 7, 3, 0, 0, 0, 0);
      checkOutput(0, BYP ? 64'hB : 64'hA, "r7_same_cycle_p0");
      checkOutput(1, BYP ? 64'hB : 64'hA, "r7_same_cycle_p1");
      checkOutput(2, 64'h12345678, "r3_unaffected_p2");
      step();

      applyStimulus(0, 0, 0, 0, 4'h1, 7, 0, 0, 0, 0, 0, 0);
      checkOutput(0, 64'hB, "r7_next_cycle");
      step();

      applyStimulus(0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 1, 64'h1111, 64'h2222);
      checkOutput(SEL_HI, BYP ? 64'h1111 : 64'h0, "hi_same_cycle");
      checkOutput(SEL_LO, BYP ? 64'h2222 : 64'h0, "lo_same_cycle");
      step();

      applyStimulus(0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 64'h7777, 64'h8888);
      checkOutput(SEL_HI, 64'h1111, "hi_next_cycle");
      checkOutput(SEL_LO, 64'h2222, "lo_next_cycle");
      step();

      applyStimulus(0, 1, 1, 64'h01234567_89ABCDEF, 4'h0, 0, 0, 0, 0, 0, 0, 0);
      step();
      applyStimulus(0, 1, 2, 64'hFEDCBA98_76543210, 4'h0, 0, 0, 0, 0, 0, 0, 0);
      step();
      applyStimulus(0, 1, 3, 64'hA5A5A5A5_5A5A5A5A, 4'h0, 0, 0, 0, 0, 0, 0, 0);
      step();
      applyStimulus(0, 1, 4, 64'h80000000_00000001, 4'h0, 0, 0, 0, 0, 0, 0, 0);
      step();

      applyStimulus(0, 0, 0, 0, 4'hF, 1, 2, 3, 4, 0, 0, 0);
      checkOutput(0, 64'h01234567_89ABCDEF, "wide_p0_r1");
      checkOutput(1, 64'hFEDCBA98_76543210, "wide_p1_r2");
      checkOutput(2, 64'hA5A5A5A5_5A5A5A5A, "wide_p2_r3");
      checkOutput(3, 64'h80000000_00000001, "wide_p3_r4");
      step();

      // Reset also beats a HI/LO write
      applyStimulus(1, 0, 0, 0, 4'hF, 1, 2, 3, 4, 1, 64'h5555, 64'h6666);
      checkOutput(SEL_HI, 0, "rst_hilo_we_hi");
      checkOutput(2, 0, "rst_wide_p2");
      step();

      applyStimulus(0, 0, 0, 0, 4'hF, 1, 2, 3, 4, 0, 0, 0);
      checkOutput(SEL_HI, 0, "hi_after_rst");
      checkOutput(SEL_LO, 0, "lo_after_rst");
      checkOutput(0, 0, "r1_after_rst");
      checkOutput(3, 0, "r4_after_rst");
      step();

      done = 1'b1;
      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
